ifetch_pc_unit: RTL

Program-counter and next-PC stage of the MIPS single-cycle CPU, directly downstream of the execute stage. It consumes the ALU's `Zero` flag and branch target `Addr_Result` plus the decoder's jump/branch controls. It holds the PC register, drives the instruction-memory word address, and supplies `PC_plus_4` back to execute and the link address to write-back. It also traps misaligned or out-of-range fetch targets in a sticky fault register.

---
 rtl/ifetch_pc_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ifetch_pc_unit.sv
// PC register and next-PC selection for the single-cycle MIPS core, with a sticky fetch-fault trap.
// Optional performance counters are built only when IFETCH_PERF_CNT_EN is defined.
module ifetch_pc_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_ADDR_W = 14
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [31:0]            Instruction,
    input  logic [31:0]            Addr_Result,
    input  logic                   Zero,
    input  logic [31:0]            Read_data_1,
    input  logic                   Branch,
    input  logic                   nBranch,
    input  logic                   Jmp,
    input  logic                   Jal,
    input  logic                   Jr,
    input  logic                   Stall,
    output logic [IMEM_ADDR_W-1:0] Imem_addr,
    output logic [31:0]            PC,
    output logic [31:0]            PC_plus_4,
    output logic [31:0]            Link_addr,
    output logic                   Fetch_fault,
    output logic [31:0]            Fault_addr,
    output logic [31:0]            Fault_pc,
    output logic [31:0]            Instr_count,
    output logic [31:0]            Taken_count
);

    // Word-aligned bits that may be set in a legal fetch address.
    localparam logic [31:0] LEGAL_MASK = (IMEM_ADDR_W >= 30) ? 32'hFFFF_FFFC :
                                         (((32'd1 << (IMEM_ADDR_W + 2)) - 32'd1) & 32'hFFFF_FFFC);

    logic [31:0] pc_q, pc_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [31:0] fault_pc_q, fault_pc_d;

    logic [31:0] pc_plus_4;
    logic [31:0] jump_target;
    logic [31:0] target;
    logic        taken;
    logic        redirect;
    logic        target_bad;
    logic        pc_update;

    logic unused_instr_bits;
    assign unused_instr_bits = ^Instruction[31:26];

    assign pc_plus_4   = pc_q + 32'd4;
    assign taken       = (Branch & Zero) | (nBranch & ~Zero);
    assign redirect    = Jr | Jmp | Jal | taken;
    assign jump_target = {pc_plus_4[31:28], Instruction[25:0], 2'b00};

    always_comb begin
        target = pc_plus_4;
        if (Jr) begin
            target = Read_data_1;
        end else if (Jmp | Jal) begin
            target = jump_target;
        end else if (taken) begin
            target = Addr_Result;
        end
    end

    // The sequential pc+4 path is never trapped, only explicit redirects.
    assign target_bad = redirect & ((target & ~LEGAL_MASK) != 32'd0);
    assign pc_update  = ~Stall & ~fault_q & ~target_bad;

    always_comb begin
        pc_d         = pc_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        fault_pc_d   = fault_pc_q;
        if (!Stall && !fault_q) begin
            if (target_bad) begin
                fault_d      = 1'b1;
                fault_addr_d = target;
                fault_pc_d   = pc_q;
            end else begin
                pc_d = target;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q         <= RESET_PC;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'd0;
            fault_pc_q   <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            fault_pc_q   <= fault_pc_d;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic [31:0] taken_cnt_q, taken_cnt_d;

    always_comb begin
        instr_cnt_d = instr_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (pc_update) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
            if (redirect) begin
                taken_cnt_d = taken_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_cnt_q <= 32'd0;
            taken_cnt_q <= 32'd0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign Instr_count = instr_cnt_q;
    assign Taken_count = taken_cnt_q;
`else
    logic unused_pc_update;
    assign unused_pc_update = pc_update;
    assign Instr_count      = 32'd0;
    assign Taken_count      = 32'd0;
`endif

    assign PC          = pc_q;
    assign PC_plus_4   = pc_plus_4;
    assign Link_addr   = pc_plus_4;
    assign Imem_addr   = pc_q[IMEM_ADDR_W+1:2];
    assign Fetch_fault = fault_q;
    assign Fault_addr  = fault_addr_q;
    assign Fault_pc    = fault_pc_q;

endmodule
